// File: rtl/display_scan_controller.sv
// Eight-digit time-multiplexing scan stage: holds host-written hex digits and
// cycles a registered digit-select/value pair at a programmable slot rate.
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] digit_mask,
    output logic [3:0] c,
    output logic [2:0] s,
    output logic       blank,
    output logic       slot_tick
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_s;
    logic [3:0]       r_c;
    logic [3:0]       r_d [8];
    logic             r_blank;
    logic             r_slot_tick;

    logic             w_tc;
    logic [2:0]       w_s_next;
    logic [PRE_W-1:0] w_pre_next;
    logic [3:0]       w_c_next;

    assign w_tc     = en && (r_pre == PRE_LAST);
    assign w_s_next = w_tc ? (r_s + 3'd1) : r_s;

    // Next prescaler value; held while scanning is disabled.
    always_comb begin
        w_pre_next = r_pre;
        if (en) begin
            if (w_tc) begin
                w_pre_next = '0;
            end else begin
                w_pre_next = r_pre + PRE_W'(1);
            end
        end
    end

    // A write aimed at the slot being shown next edge bypasses storage, so c
    // always mirrors d[s] with no stale cycle.
    always_comb begin
        w_c_next = r_c;
        if (wr_en && (wr_addr == w_s_next)) begin
            w_c_next = wr_data;
        end else if (w_tc) begin
            w_c_next = r_d[w_s_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_s         <= '0;
            r_c         <= '0;
            r_blank     <= 1'b0;
            r_slot_tick <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            r_pre       <= w_pre_next;
            r_s         <= w_s_next;
            r_c         <= w_c_next;
            r_blank     <= ~digit_mask[w_s_next];
            r_slot_tick <= w_tc;
            if (wr_en) begin
                r_d[wr_addr] <= wr_data;
            end
        end
    end

    assign c         = r_c;
    assign s         = r_s;
    assign blank     = r_blank;
    assign slot_tick = r_slot_tick;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: a behavioural model pushes the
// expected output word for every edge and the popped entry is compared after it.
module tb_display_scan_controller;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [7:0] digit_mask = 8'hFF;
    logic [3:0] c;
    logic [2:0] s;
    logic       blank;
    logic       slot_tick;

    display_scan_controller #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_mask (digit_mask),
        .c          (c),
        .s          (s),
        .blank      (blank),
        .slot_tick  (slot_tick)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] c;
        logic [2:0] s;
        logic       blank;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state; c is expected to equal d[s] at all times.
    int         m_pre;
    logic [2:0] m_s;
    logic [3:0] m_d [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_s   = '0;
        for (int i = 0; i < 8; i++) m_d[i] = '0;
    endtask

    // One clock edge: predict, push, clock, pop and compare.
    task automatic tick();
        exp_t e;
        exp_t got;
        logic tc;
        tc = en && (m_pre == int'(DIV) - 1);
        if (en) m_pre = tc ? 0 : m_pre + 1;
        if (tc) m_s = m_s + 3'd1;
        if (wr_en) m_d[wr_addr] = wr_data;
        e.c     = m_d[m_s];
        e.s     = m_s;
        e.blank = ~digit_mask[m_s];
        e.tick  = tc;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = {c, s, blank, slot_tick};
        e   = q.pop_front();
        chk("scoreboard", 32'(got), 32'(e));
    endtask

    task automatic run_until(input string tag, input logic [2:0] ts, input int tp);
        int n = 0;
        while (!(m_s == ts && m_pre == tp) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_reached"}, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nt;
        int n;

        // Reset with no clock edges.
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        chk("rst_tick", 32'(slot_tick), 32'd0);
        en = 1'b1;
        rst_n = 1'b1;
        clk_run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("first_tick", 32'(slot_tick), 32'd1);
        chk("first_s", 32'(s), 32'd1);

        // Full scan: load d[i]=i+8, then follow through a wrap to s=0.
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 8);
            tick();
        end
        wr_en = 1'b0;
        n = 0;
        while (!(slot_tick && s == 3'd0) && n < 64) begin
            tick();
            n++;
        end
        chk("wrap_reached", 32'(n < 64), 32'd1);
        chk("wrap_c", 32'(c), 32'h8);
        for (int i = 0; i < 32; i++) tick();
        chk("period_s", 32'(s), 32'd0);
        chk("period_tick", 32'(slot_tick), 32'd1);

        // Bypass writes.
        run_until("bypass", 3'd3, 0);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
        tick();
        chk("bypass_same", 32'(c), 32'hA);
        wr_addr = 3'd5; wr_data = 4'h2;
        tick();
        chk("bypass_other", 32'(c), 32'hA);
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h7;
        tick();
        wr_en = 1'b0;
        chk("bypass_adv_s", 32'(s), 32'd4);
        chk("bypass_adv_c", 32'(c), 32'h7);

        // Blanking across one full scan period.
        digit_mask = 8'b1010_0101;
        nb = 0;
        nt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            nb += int'(blank);
            nt += int'(slot_tick);
        end
        chk("blank_cycles", 32'(nb), 32'd16);
        chk("blank_slots", 32'(nt), 32'd8);

        // Enable freeze at pre=2, s=5.
        run_until("freeze", 3'd5, 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("freeze_s", 32'(s), 32'd5);
        en = 1'b1;
        tick();
        chk("resume_hold", 32'(s), 32'd5);
        tick();
        chk("resume_s", 32'(s), 32'd6);
        chk("resume_tick", 32'(slot_tick), 32'd1);

        // Asynchronous reset between edges while s=6.
        run_until("areset", 3'd6, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_c", 32'(c), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_blank", 32'(blank), 32'd0);
        chk("arst_tick", 32'(slot_tick), 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (slot_tick) chk("arst_slot_c", 32'(c), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
